dn_load_sink: RTL
=================

Name: dn_load_sink

Overview:
- Receiving end of the boot-loader download stream (dn_go/dn_wr/dn_addr/dn_data, execute_addr/execute_enable) inside pcw_core.
- Buffers incoming bytes in a small FIFO and writes them into shared PCW RAM through a request/acknowledge port, because the loader streams without backpressure.
- Holds the Z80 off the bus while loading. After the last byte is committed, releases the CPU and optionally issues a jump request to the execute address.

Parameters:
- FIFO_DEPTH, 8, number of buffered {addr,data} entries; power of two, >=2.
- BASE_ADDR, 21'h000000, physical RAM address added to dn_addr.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- dn_go  in  1  loader session active (level).
- dn_wr  in  1  byte strobe, qualified by dn_go.
- dn_addr  in  16  CPU address of byte.
- dn_data  in  8  byte value.
- execute_enable  in  1  one-cycle pulse requesting a jump.
- execute_addr  in  16  jump target, sampled with execute_enable.
- mem_addr  out  21  RAM write address.
- mem_din  out  8  RAM write data.
- mem_wr  out  1  write request.
- mem_ack  in  1  RAM accepted write.
- cpu_hold  out  1  keep Z80 in reset / off bus.
- jump_req  out  1  one-cycle pulse: CPU PC load.
- jump_addr  out  16  PC value, valid while jump_req=1.
- load_done  out  1  one-cycle pulse at session end.
- overflow  out  1  sticky: a byte was dropped.
- byte_count  out  17  accepted bytes this session.

Behaviour:
- Reset values: mem_wr=0, mem_addr=0, mem_din=0, cpu_hold=1, jump_req=0, jump_addr=0, load_done=0, overflow=0, byte_count=0. FIFO emptied, exec_pending=0, state IDLE.
- Reset is honoured in any state, including mid-load. No write is issued in the reset cycle or the cycle after.
- States: IDLE, LOAD, DRAIN, FINISH.
- IDLE -> LOAD on dn_go=1. On entry: overflow, byte_count and exec_pending cleared; cpu_hold=1.
- Push: in any cycle with dn_go&&dn_wr in LOAD or DRAIN, the entry {BASE_ADDR+dn_addr, dn_data} is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs in the same cycle.
  - Accepted byte: byte_count+1, saturating at 17'h1FFFF.
  - Otherwise the byte is dropped and overflow is set.
  - Each strobe cycle counts as one byte.
- Address arithmetic: 21-bit sum of BASE_ADDR and zero-extended dn_addr; wraps modulo 2^21.
- Pop: mem_wr=1 whenever the FIFO is non-empty; mem_addr/mem_din show the head entry, registered, with zero combinational path from dn_*.
  - A transfer completes in a cycle where mem_wr&&mem_ack; the head pops.
  - The next entry is presented the following cycle, so one write per cycle is possible.
  - mem_addr/mem_din stay stable while mem_wr=1 and mem_ack=0.
  - mem_ack while mem_wr=0 is ignored.
- execute_enable=1 in LOAD or DRAIN: latch execute_addr, set exec_pending. A later pulse overwrites the latched address. Pulses in IDLE/FINISH are ignored.
- LOAD -> DRAIN when dn_go=0. DRAIN -> LOAD if dn_go returns to 1; FIFO, overflow and count are kept.
- DRAIN -> FINISH when FIFO empty and no transfer pending.
- FINISH, single cycle:
  - load_done=1; cpu_hold=0 from this cycle on.
  - If exec_pending: jump_req=1 and jump_addr=latched address in the same cycle.
  - Then IDLE.
- cpu_hold stays 0 in IDLE until the next dn_go or reset.
- Latency: a byte accepted at cycle N with an empty FIFO produces mem_wr=1 at cycle N+1.
- Empty FIFO: mem_wr=0 the cycle after the last pop.

Test Plan:
- 276-byte session (dn_wr every 2nd cycle, addr 0..275), mem_ack tied 1, execute_enable with execute_addr=16'h0000 on the dn_go fall cycle -> 276 writes at mem_addr 0..275 in order, byte_count=276, overflow=0, one load_done, jump_req with jump_addr=0, cpu_hold 1->0 in the FINISH cycle.
- BASE_ADDR=21'h1FFF00, dn_addr 16'h0100 -> mem_addr 21'h000000 (wrap).
- mem_ack held 0 for 20 cycles during streaming (10 strobes), FIFO_DEPTH=8 -> the first 8 bytes are buffered, strobes 9 and 10 are dropped, overflow=1, byte_count=8. After mem_ack returns: exactly 8 writes, mem_addr/mem_din stable throughout the stall.
- FIFO full, push and ack in the same cycle -> byte accepted, count stays 8, no overflow.
- execute_enable (execute_addr=16'h1234) while 5 entries remain -> jump_req occurs only after the 5th mem_ack, with jump_addr=16'h1234.
- reset asserted mid-LOAD with 4 entries buffered -> next cycle mem_wr=0, cpu_hold=1, byte_count=0. No further writes until a new dn_go; a pending jump never fires.

Source files
------------

// File: rtl/dn_load_sink.sv
// Receiving end of the boot-loader download stream: buffers {addr,data} bytes in a
// small FIFO, writes them to PCW RAM over a req/ack port, then releases the Z80.
module dn_load_sink #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [20:0] BASE_ADDR  = 21'h000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dn_go,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        execute_enable,
  input  logic [15:0] execute_addr,
  output logic [20:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_wr,
  input  logic        mem_ack,
  output logic        cpu_hold,
  output logic        jump_req,
  output logic [15:0] jump_addr,
  output logic        load_done,
  output logic        overflow,
  output logic [16:0] byte_count
);

  localparam int             PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0]    FULL_COUNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [16:0]    COUNT_MAX  = 17'h1FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  state_t        state, state_nxt;

  logic [20:0]   fifo_addr [FIFO_DEPTH];
  logic [7:0]    fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  logic          exec_pending;
  logic [15:0]   exec_addr;
  logic          hold_q;
  logic          overflow_q;
  logic [16:0]   byte_count_q;

  logic          fifo_valid, fifo_full, loading;
  logic          push_req, push, pop;
  logic          session_start;
  logic [20:0]   entry_addr;

  // Datapath strobes. Outputs come only from FIFO registers, never from dn_*.
  // NOTE: every signal driven in always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    fifo_valid = (count != '0);
    fifo_full  = (count == FULL_COUNT);
    loading    = (state == ST_LOAD) || (state == ST_DRAIN);
    pop        = fifo_valid && mem_ack;
    push_req   = loading && dn_go && dn_wr;
    push       = push_req && (!fifo_full || pop);
    entry_addr = BASE_ADDR + {5'b0, dn_addr};

    mem_wr     = fifo_valid && !reset;
    mem_addr   = fifo_valid ? fifo_addr[rd_ptr] : '0;
    mem_din    = fifo_valid ? fifo_data[rd_ptr] : '0;
  end

  // Next-state and FSM-decoded pulse outputs.
  always_comb begin
    state_nxt     = state;
    session_start = 1'b0;
    load_done     = 1'b0;
    jump_req      = 1'b0;
    jump_addr     = '0;
    unique case (state)
      ST_IDLE: begin
        if (dn_go) begin
          state_nxt     = ST_LOAD;
          session_start = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!dn_go) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (dn_go)            state_nxt = ST_LOAD;
        else if (!fifo_valid) state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        load_done = 1'b1;
        if (exec_pending) begin
          jump_req  = 1'b1;
          jump_addr = exec_addr;
        end
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the FIFO storage has no reset; count gates every use of it, so stale
  // contents are never observed and the array can map onto plain RAM cells.
  always_ff @(posedge clk_sys) begin
    if (push && !reset) begin
      fifo_addr[wr_ptr] <= entry_addr;
      fifo_data[wr_ptr] <= dn_data;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state  <= ST_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Session bookkeeping: hold, counters, overflow and the deferred jump.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold_q       <= 1'b1;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
      exec_pending <= 1'b0;
      exec_addr    <= '0;
    end else begin
      if (session_start)               hold_q <= 1'b1;
      else if (state_nxt == ST_FINISH) hold_q <= 1'b0;

      if (session_start) begin
        overflow_q   <= 1'b0;
        byte_count_q <= '0;
        exec_pending <= 1'b0;
      end else begin
        if (push && byte_count_q != COUNT_MAX) byte_count_q <= byte_count_q + 17'd1;
        if (push_req && !push)                 overflow_q   <= 1'b1;
        if (loading && execute_enable) begin
          exec_addr    <= execute_addr;
          exec_pending <= 1'b1;
        end else if (state == ST_FINISH) begin
          exec_pending <= 1'b0;
        end
      end
    end
  end

  assign cpu_hold   = hold_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;

endmodule
